load_store_unit: RTL and testbench

- Multicycle load/store unit sitting directly upstream of sign_extender in the part2 datapath.
- Accepts one memory op from execute and drives a req/gnt/rvalid data-memory port with word-aligned address, byte enables and lane-replicated store data.
- For loads, returns the addressed byte/half/word shifted to bit 0 and zero-filled above, plus the 1–5 load-type code that sign_extender consumes.

---
 rtl/riscv_lsu_pkg.sv | 36 +++
 rtl/load_store_unit_if.sv | 24 ++
 rtl/lsu_lane_align.sv | 43 ++++
 rtl/load_store_unit.sv | 117 +++++++++++
 tb/tb_load_store_unit.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit and its downstream sign_extender:
// funct3 encodings, load-type codes and the LSU state encoding.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] LT_NONE = 3'd0;
  localparam logic [2:0] LT_LB   = 3'd1;
  localparam logic [2:0] LT_LH   = 3'd2;
  localparam logic [2:0] LT_LW   = 3'd3;
  localparam logic [2:0] LT_LBU  = 3'd4;
  localparam logic [2:0] LT_LHU  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_t;

  function automatic logic [2:0] load_type(input logic [2:0] f3);
    case (f3)
      F3_B:    return LT_LB;
      F3_H:    return LT_LH;
      F3_W:    return LT_LW;
      F3_BU:   return LT_LBU;
      F3_HU:   return LT_LHU;
      default: return LT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/gnt/rvalid port between the LSU (master) and memory (slave).
interface load_store_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          data_req;
  logic          data_gnt;
  logic [AW-1:0] data_addr;
  logic          data_we;
  logic [3:0]    data_be;
  logic [DW-1:0] data_wdata;
  logic          data_rvalid;
  logic [DW-1:0] data_rdata;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables, store-data replication, load-data
// extraction (shifted to bit 0, zero-filled) and misalignment/illegal-op flag.
module lsu_lane_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        err
);

  always_comb begin
    be        = '0;
    wdata_rep = wdata;
    rdata_ext = rdata;
    err       = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = (rdata >> {addr_lo, 3'b000}) & 32'h0000_00FF;
        err       = we && (funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'h0000, addr_lo[1] ? rdata[31:16] : rdata[15:0]};
        err       = addr_lo[0] || (we && (funct3 == F3_HU));
      end
      F3_W: begin
        be  = 4'b1111;
        err = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: one op from execute, one req/gnt/rvalid memory
// transaction, then a one-cycle completion pulse with aligned load data.
module load_store_unit
  import riscv_lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic                ex_we,
  input  logic [2:0]          ex_funct3,
  input  logic [AW-1:0]       ex_addr,
  input  logic [DW-1:0]       ex_wdata,
  load_store_unit_if.master   dmem,
  output logic                lsu_valid,
  output logic [DW-1:0]       lsu_rdata,
  output logic [2:0]          lsu_type,
  output logic                lsu_err
);

  lsu_state_t  state;
  logic        op_we;
  logic [2:0]  op_f3;
  logic [1:0]  op_lo;

  logic        al_we;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_err;

  assign ex_ready = (state == ST_IDLE);

  // One aligner serves both phases: live request fields while idle (be/wdata/err),
  // latched fields afterwards (load extraction on rvalid).
  assign al_we = ex_ready ? ex_we            : op_we;
  assign al_f3 = ex_ready ? ex_funct3        : op_f3;
  assign al_lo = ex_ready ? ex_addr[1:0]     : op_lo;

  lsu_lane_align u_align (
    .funct3    (al_f3),
    .we        (al_we),
    .addr_lo   (al_lo),
    .wdata     (ex_wdata),
    .rdata     (dmem.data_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .err       (al_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      op_we           <= 1'b0;
      op_f3           <= '0;
      op_lo           <= '0;
      dmem.data_req   <= 1'b0;
      dmem.data_addr  <= '0;
      dmem.data_we    <= 1'b0;
      dmem.data_be    <= '0;
      dmem.data_wdata <= '0;
      lsu_valid       <= 1'b0;
      lsu_rdata       <= '0;
      lsu_type        <= LT_NONE;
      lsu_err         <= 1'b0;
    end else begin
      lsu_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            op_we <= ex_we;
            op_f3 <= ex_funct3;
            op_lo <= ex_addr[1:0];
            if (al_err) begin
              state     <= ST_RESP;
              lsu_valid <= 1'b1;
              lsu_err   <= 1'b1;
              lsu_type  <= LT_NONE;
              lsu_rdata <= '0;
            end else begin
              state           <= ST_REQ;
              dmem.data_req   <= 1'b1;
              dmem.data_addr  <= {ex_addr[AW-1:2], 2'b00};
              dmem.data_we    <= ex_we;
              dmem.data_be    <= al_be;
              dmem.data_wdata <= al_wdata;
            end
          end
        end
        ST_REQ: begin
          if (dmem.data_gnt) begin
            dmem.data_req <= 1'b0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dmem.data_rvalid) begin
            state     <= ST_RESP;
            lsu_valid <= 1'b1;
            lsu_err   <= 1'b0;
            lsu_type  <= op_we ? LT_NONE : load_type(op_f3);
            lsu_rdata <= op_we ? '0 : al_rdata;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors for loads, stores,
// error ops, a stalled grant and reset during an outstanding access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_we;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        lsu_valid;
  logic [31:0] lsu_rdata;
  logic [2:0]  lsu_type;
  logic        lsu_err;

  int checks = 0;
  int errors = 0;

  load_store_unit_if #(.AW(32), .DW(32)) dmem ();

  load_store_unit #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_we     (ex_we),
    .ex_funct3 (ex_funct3),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .dmem      (dmem.master),
    .lsu_valid (lsu_valid),
    .lsu_rdata (lsu_rdata),
    .lsu_type  (lsu_type),
    .lsu_err   (lsu_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and walk it through the handshake, checking every cycle.
  task automatic run_op(
    input string       name,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input int unsigned gnt_wait,
    input logic [31:0] rdata,
    input logic        exp_err,
    input logic [31:0] exp_addr,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wdata,
    input logic [31:0] exp_rdata,
    input logic [2:0]  exp_type
  );
    check({name, " ready"}, 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex_we = we; ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
    tick();
    ex_valid = 1'b0;
    if (exp_err) begin
      check({name, " err valid"}, 32'(lsu_valid), 32'd1);
      check({name, " err flag"}, 32'(lsu_err), 32'd1);
      check({name, " err type"}, 32'(lsu_type), 32'd0);
      check({name, " err rdata"}, lsu_rdata, 32'd0);
      check({name, " err no req"}, 32'(dmem.data_req), 32'd0);
      tick();
      check({name, " err pulse"}, 32'(lsu_valid), 32'd0);
      check({name, " err req idle"}, 32'(dmem.data_req), 32'd0);
      return;
    end
    for (int unsigned i = 0; i <= gnt_wait; i++) begin
      check({name, " req"}, 32'(dmem.data_req), 32'd1);
      check({name, " addr"}, dmem.data_addr, exp_addr);
      check({name, " be"}, 32'(dmem.data_be), 32'(exp_be));
      check({name, " we"}, 32'(dmem.data_we), 32'(we));
      if (we) check({name, " wdata"}, dmem.data_wdata, exp_wdata);
      check({name, " busy"}, 32'(ex_ready), 32'd0);
      check({name, " early valid"}, 32'(lsu_valid), 32'd0);
      if (i == gnt_wait) dmem.data_gnt = 1'b1;
      tick();
    end
    dmem.data_gnt = 1'b0;
    check({name, " req drop"}, 32'(dmem.data_req), 32'd0);
    check({name, " wait valid"}, 32'(lsu_valid), 32'd0);
    dmem.data_rvalid = 1'b1;
    dmem.data_rdata  = rdata;
    tick();
    dmem.data_rvalid = 1'b0;
    dmem.data_rdata  = 32'h0;
    check({name, " valid"}, 32'(lsu_valid), 32'd1);
    check({name, " rdata"}, lsu_rdata, exp_rdata);
    check({name, " type"}, 32'(lsu_type), 32'(exp_type));
    check({name, " err"}, 32'(lsu_err), 32'd0);
    tick();
    check({name, " pulse"}, 32'(lsu_valid), 32'd0);
    check({name, " hold"}, lsu_rdata, exp_rdata);
    check({name, " hold type"}, 32'(lsu_type), 32'(exp_type));
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_we = 1'b0; ex_funct3 = 3'b000; ex_addr = '0; ex_wdata = '0;
    dmem.data_gnt = 1'b0; dmem.data_rvalid = 1'b0; dmem.data_rdata = '0;
    tick(); tick();
    check("rst req", 32'(dmem.data_req), 32'd0);
    check("rst addr", dmem.data_addr, 32'd0);
    check("rst be", 32'(dmem.data_be), 32'd0);
    check("rst valid", 32'(lsu_valid), 32'd0);
    check("rst ready", 32'(ex_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    //      name    we    f3      addr          wdata         gw rdata         err   eaddr         be       ewdata        erdata        type
    run_op("lw",   1'b0, 3'b010, 32'h0000_0100, 32'h0,        0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF, 3'd3);
    run_op("lb",   1'b0, 3'b000, 32'h0000_0103, 32'h0,        0, 32'h80FF_0000, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080, 3'd1);
    run_op("lbu",  1'b0, 3'b100, 32'h0000_0103, 32'h0,        0, 32'h80FF_0000, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080, 3'd4);
    run_op("sh",   1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0,        3'd0);
    run_op("lhmis",1'b0, 3'b001, 32'h0000_0101, 32'h0,        0, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        3'd0);
    run_op("lwst", 1'b0, 3'b010, 32'h0000_0100, 32'h0,        5, 32'h0BAD_F00D, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0BAD_F00D, 3'd3);
    run_op("lhu",  1'b0, 3'b101, 32'h0000_0102, 32'h0,        0, 32'h89AB_CDEF, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,        32'h0000_89AB, 3'd5);
    run_op("lh",   1'b0, 3'b001, 32'h0000_0300, 32'h0,        1, 32'h89AB_CDEF, 1'b0, 32'h0000_0300, 4'b0011, 32'h0,        32'h0000_CDEF, 3'd2);
    run_op("sb",   1'b1, 3'b000, 32'h0000_0101, 32'h0000_0055, 0, 32'h0,        1'b0, 32'h0000_0100, 4'b0010, 32'h5555_5555, 32'h0,        3'd0);
    run_op("sw",   1'b1, 3'b010, 32'h0000_0404, 32'hCAFE_0001, 0, 32'h0,        1'b0, 32'h0000_0404, 4'b1111, 32'hCAFE_0001, 32'h0,        3'd0);
    run_op("f3ill",1'b0, 3'b011, 32'h0000_0100, 32'h0,        0, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        3'd0);
    run_op("sbu",  1'b1, 3'b100, 32'h0000_0100, 32'h0,        0, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        3'd0);
    run_op("lwmis",1'b0, 3'b010, 32'h0000_0102, 32'h0,        0, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        3'd0);
    run_op("lbok", 1'b0, 3'b000, 32'h0000_0101, 32'h0,        0, 32'h1122_3344, 1'b0, 32'h0000_0100, 4'b0010, 32'h0,        32'h0000_0033, 3'd1);

    // Reset while the load is outstanding in WAIT; lsu_rdata is nonzero beforehand.
    ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h0000_0500;
    tick();
    ex_valid = 1'b0;
    dmem.data_gnt = 1'b1;
    tick();
    dmem.data_gnt = 1'b0;
    check("mid wait req", 32'(dmem.data_req), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst req", 32'(dmem.data_req), 32'd0);
    check("mid rst addr", dmem.data_addr, 32'd0);
    check("mid rst be", 32'(dmem.data_be), 32'd0);
    check("mid rst rdata", lsu_rdata, 32'd0);
    check("mid rst ready", 32'(ex_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    dmem.data_rvalid = 1'b1;
    dmem.data_rdata  = 32'h7777_7777;
    tick();
    dmem.data_rvalid = 1'b0;
    check("late rvalid", 32'(lsu_valid), 32'd0);
    tick();
    check("late rvalid2", 32'(lsu_valid), 32'd0);
    check("late rdata", lsu_rdata, 32'd0);
    run_op("post", 1'b0, 3'b010, 32'h0000_0600, 32'h0,        0, 32'h0102_0304, 1'b0, 32'h0000_0600, 4'b1111, 32'h0,        32'h0102_0304, 3'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
